pixel_upscale_2x: RTL and testbench

PIXEL_UPSCALE_2X -- requirements
Module: pixel_upscale_2x

---
 rtl/pixel_upscale_2x.sv | 154 +++++++++++++++
 tb/tb_pixel_upscale_2x.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pixel_upscale_2x.sv
// rtl/pixel_upscale_2x.sv - 2x nearest-neighbour grayscale upscaler with line buffer and 2-cycle timing pipeline
module pixel_upscale_2x #(
    parameter int SRC_W = 225,
    parameter int SRC_H = 225
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_vs,
    input  logic       i_hs,
    input  logic       i_de,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       o_vs,
    output logic       o_hs,
    output logic       o_de,
    output logic [7:0] o_pix,
    output logic       o_underflow
);

    localparam int          AW    = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam logic [10:0] X_LIM = 11'(2 * SRC_W);
    localparam logic [10:0] Y_LIM = 11'(2 * SRC_H);

    typedef enum logic {WAIT_VS, ACTIVE} state_t;

    state_t      state_q, state_d;
    logic        vs_prev_q, vs_prev_d;
    logic        de_prev_q, de_prev_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [7:0]  held_q, held_d;
    logic        uf_q, uf_d;

    logic        vs1_q, vs1_d, hs1_q, hs1_d, de1_q, de1_d;
    logic        win1_q, win1_d, odd1_q, odd1_d;
    logic [7:0]  pix1_q, pix1_d;
    logic        vs2_q, vs2_d, hs2_q, hs2_d, de2_q, de2_d;
    logic [7:0]  pix2_q, pix2_d;

    logic [7:0]  lbuf [SRC_W];
    logic [7:0]  rd_q;

    logic        vs_fall, de_fall, in_win, wr_en, rd_en;
    logic [7:0]  pix_in;
    logic [AW-1:0] addr;

    always_comb begin
        vs_fall = vs_prev_q & ~i_vs;
        de_fall = de_prev_q & ~i_de;
        in_win  = (state_q == ACTIVE) && i_de && (x_q < X_LIM) && (y_q < Y_LIM);
        s_ready = in_win & ~x_q[0] & ~y_q[0];
        pix_in  = s_valid ? s_data : 8'd0;
        addr    = x_q[AW:1];
        wr_en   = s_ready;
        rd_en   = in_win & y_q[0];

        state_d = state_q;
        if (state_q == WAIT_VS && vs_fall) begin
            state_d = ACTIVE;
        end

        x_d = x_q;
        y_d = y_q;
        if (vs_fall) begin
            x_d = 11'd0;
            y_d = 11'd0;
        end else begin
            if (state_q == ACTIVE && i_de) begin
                x_d = x_q + 11'd1;
            end else if (de_fall) begin
                x_d = 11'd0;
            end
            if (de_fall) begin
                y_d = y_q + 11'd1;
            end
        end

        // held pixel covers the duplicated odd column on even rows
        held_d    = s_ready ? pix_in : held_q;
        uf_d      = uf_q | (s_ready & ~s_valid);
        vs_prev_d = i_vs;
        de_prev_d = i_de;

        vs1_d  = i_vs;
        hs1_d  = i_hs;
        de1_d  = i_de;
        win1_d = in_win;
        odd1_d = y_q[0];
        pix1_d = held_d;

        vs2_d  = vs1_q;
        hs2_d  = hs1_q;
        de2_d  = de1_q;
        pix2_d = win1_q ? (odd1_q ? rd_q : pix1_q) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= WAIT_VS;
            vs_prev_q <= 1'b0;
            de_prev_q <= 1'b0;
            x_q       <= 11'd0;
            y_q       <= 11'd0;
            held_q    <= 8'd0;
            uf_q      <= 1'b0;
            vs1_q     <= 1'b1;
            hs1_q     <= 1'b1;
            de1_q     <= 1'b0;
            win1_q    <= 1'b0;
            odd1_q    <= 1'b0;
            pix1_q    <= 8'd0;
            vs2_q     <= 1'b1;
            hs2_q     <= 1'b1;
            de2_q     <= 1'b0;
            pix2_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            vs_prev_q <= vs_prev_d;
            de_prev_q <= de_prev_d;
            x_q       <= x_d;
            y_q       <= y_d;
            held_q    <= held_d;
            uf_q      <= uf_d;
            vs1_q     <= vs1_d;
            hs1_q     <= hs1_d;
            de1_q     <= de1_d;
            win1_q    <= win1_d;
            odd1_q    <= odd1_d;
            pix1_q    <= pix1_d;
            vs2_q     <= vs2_d;
            hs2_q     <= hs2_d;
            de2_q     <= de2_d;
            pix2_q    <= pix2_d;
        end
    end

    // line buffer: writes only on even rows, reads only on odd rows
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lbuf[addr] <= pix_in;
        end
        if (rd_en) begin
            rd_q <= lbuf[addr];
        end
    end

    assign o_vs        = vs2_q;
    assign o_hs        = hs2_q;
    assign o_de        = de2_q;
    assign o_pix       = pix2_q;
    assign o_underflow = uf_q;

endmodule

// File: tb/tb_pixel_upscale_2x.sv
// tb/tb_pixel_upscale_2x.sv - randomized self-checking bench for pixel_upscale_2x on a reduced raster
module tb_pixel_upscale_2x;

    localparam int SW    = 5;
    localparam int SH    = 3;
    localparam int H_ACT = 14;
    localparam int H_TOT = 20;
    localparam int V_TOT = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_vs = 1'b1, i_hs = 1'b1, i_de = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_ready, o_vs, o_hs, o_de, o_underflow;
    logic [7:0] o_pix;

    pixel_upscale_2x #(.SRC_W(SW), .SRC_H(SH)) dut (
        .clk(clk), .rst_n(rst_n), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de), .o_pix(o_pix), .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vs, hs, de;
        logic [7:0] pix;
        bit         chk;
    } exp_t;

    int         errors = 0;
    int         checks = 0;
    int         idx = 0;
    int         dut_pops = 0;
    logic [7:0] src [0:1023];
    logic [7:0] lb [0:SW-1];
    bit         armed = 0;
    bit         uf = 0;
    logic       prev_vs = 1'b1;
    exp_t       q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic vs, input logic hs, input logic de, input int row, input int col,
                        input logic valid, input bit chk_data);
        exp_t       e;
        bit         win, rdy;
        logic [7:0] v;
        @(negedge clk);
        if (q.size() == 2) begin
            e = q.pop_front();
            chk("o_vs", o_vs, e.vs);
            chk("o_hs", o_hs, e.hs);
            chk("o_de", o_de, e.de);
            if (e.chk) chk("o_pix", o_pix, e.pix);
        end
        if (chk_data) chk("o_underflow", o_underflow, uf);
        if (prev_vs && !vs) armed = 1;
        prev_vs = vs;
        i_vs    = vs;
        i_hs    = hs;
        i_de    = de;
        s_valid = valid;
        s_data  = valid ? src[idx] : 8'($urandom);
        win = armed && de && row >= 0 && row < 2 * SH && col >= 0 && col < 2 * SW;
        rdy = win && (row % 2 == 0) && (col % 2 == 0);
        #1;
        if (chk_data) chk("s_ready", s_ready, rdy);
        if (s_ready && s_valid) dut_pops++;
        if (rdy) begin
            v = valid ? src[idx] : 8'd0;
            if (valid) idx++;
            else uf = 1;
            lb[col / 2] = v;
        end
        e.vs  = vs;
        e.hs  = hs;
        e.de  = de;
        e.pix = win ? lb[col / 2] : 8'd0;
        e.chk = chk_data;
        q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        q.delete();
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, -1, -1, 1'b0, 1'b0);
        chk("rst_o_vs", o_vs, 1);
        chk("rst_o_hs", o_hs, 1);
        chk("rst_o_de", o_de, 0);
        chk("rst_o_pix", o_pix, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_o_underflow", o_underflow, 0);
        rst_n = 1'b1;
        armed = 0;
        uf    = 0;
        q.delete();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, -1, -1, 1'b0, 1'b1);
    endtask

    // mode 0: source always valid, 1: random gaps, 2: single gap at row 0 column 4
    task automatic frame(input int l0, input int l1, input int mode);
        logic vs, hs, de, valid;
        int   row, col;
        for (int line = l0; line < l1; line++) begin
            for (int p = 0; p < H_TOT; p++) begin
                vs  = !(line < 2);
                hs  = !(p == 15 || p == 16);
                de  = (line >= 3 && line < V_TOT - 1) && p < H_ACT;
                row = (line >= 3 && line < V_TOT - 1) ? line - 3 : -1;
                col = de ? p : -1;
                case (mode)
                    0:       valid = 1'b1;
                    1:       valid = ($urandom_range(0, 5) != 0);
                    default: valid = !(row == 0 && p == 4);
                endcase
                step(vs, hs, de, row, col, valid, 1'b1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) src[i] = 8'($urandom);
        do_reset(3);

        for (int i = 0; i < 150; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), -1, -1, 1'b1, 1'b0);
        do_reset(2);

        dut_pops = 0;
        frame(0, V_TOT, 0);
        chk("pops_frame", dut_pops, SW * SH);
        frame(0, V_TOT, 1);
        frame(0, V_TOT, 2);
        dut_pops = 0;
        frame(0, V_TOT, 0);
        chk("pops_after_underflow", dut_pops, SW * SH);

        frame(0, 6, 1);
        do_reset(2);
        dut_pops = 0;
        frame(6, V_TOT, 1);
        chk("pops_aborted_frame", dut_pops, 0);
        dut_pops = 0;
        frame(0, V_TOT, 0);
        chk("pops_after_abort", dut_pops, SW * SH);
        frame(0, V_TOT, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, -1, -1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
